// File: rtl/tile_shuffler_if.sv
// Handshake and result bundle for tile_shuffler.
// Master drives requests and seed, slave returns status and orders.
interface tile_shuffler_if #(
    parameter int N_EDGE   = 24,
    parameter int N_CENTER = 12,
    parameter int IDX_W    = 5
) ();
    logic                      start;
    logic                      seed_load;
    logic [15:0]               seed;
    logic                      busy;
    logic                      done;
    logic [N_EDGE*IDX_W-1:0]   edge_order;
    logic [N_CENTER*IDX_W-1:0] center_order;

    modport master (
        output start, seed_load, seed,
        input  busy, done, edge_order, center_order
    );

    modport slave (
        input  start, seed_load, seed,
        output busy, done, edge_order, center_order
    );
endinterface

// File: rtl/tile_shuffler.sv
// LFSR-driven Fisher-Yates shuffler for edge and centre tile orders.
// Results are held in output registers until the next completed shuffle.
module tile_shuffler #(
    parameter int          N_EDGE   = 24,
    parameter int          N_CENTER = 12,
    parameter int          IDX_W    = 5,
    parameter logic [15:0] SEED_RST = 16'hACE1
) (
    input  logic            clk,
    input  logic            rst,
    tile_shuffler_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_SH_E, S_SH_C, S_DONE
    } state_t;

    typedef logic [IDX_W-1:0] idx_t;

    localparam idx_t I_EDGE_TOP   = idx_t'(N_EDGE - 1);
    localparam idx_t I_CENTER_TOP = idx_t'(N_CENTER - 1);
    localparam idx_t I_ONE        = idx_t'(1);

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    idx_t        i_q, i_d;
    idx_t        work_e_q [N_EDGE];
    idx_t        work_e_d [N_EDGE];
    idx_t        work_c_q [N_CENTER];
    idx_t        work_c_d [N_CENTER];
    idx_t        edge_q   [N_EDGE];
    idx_t        edge_d   [N_EDGE];
    idx_t        center_q [N_CENTER];
    idx_t        center_d [N_CENTER];

    idx_t mask;
    idx_t r;
    logic accept;
    idx_t e_at_i, e_at_r;
    idx_t c_at_i, c_at_r;

    // Galois LFSR free-runs every cycle; a seed load wins over the shift.
    always_comb begin
        lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
        if (bus.seed_load) begin
            lfsr_d = (bus.seed == 16'h0000) ? SEED_RST : bus.seed;
        end
    end

    // Candidate index: LFSR masked to the smallest all-ones cover of i.
    always_comb begin
        mask = i_q;
        for (int s = 1; s < IDX_W; s++) begin
            mask = mask | (i_q >> s);
        end
        r      = lfsr_q[IDX_W-1:0] & mask;
        accept = (r <= i_q);
    end

    // Fetch the two entries that an accepted step would exchange.
    always_comb begin
        e_at_i = '0;
        e_at_r = '0;
        c_at_i = '0;
        c_at_r = '0;
        for (int k = 0; k < N_EDGE; k++) begin
            if (idx_t'(k) == i_q) e_at_i = work_e_q[k];
            if (idx_t'(k) == r)   e_at_r = work_e_q[k];
        end
        for (int k = 0; k < N_CENTER; k++) begin
            if (idx_t'(k) == i_q) c_at_i = work_c_q[k];
            if (idx_t'(k) == r)   c_at_r = work_c_q[k];
        end
    end

    // Sequencer: next state, index walk, swaps and result capture.
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        work_e_d = work_e_q;
        work_c_d = work_c_q;
        edge_d   = edge_q;
        center_d = center_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_INIT;
            end
            S_INIT: begin
                for (int k = 0; k < N_EDGE; k++) work_e_d[k] = idx_t'(k);
                for (int k = 0; k < N_CENTER; k++) work_c_d[k] = idx_t'(k);
                i_d     = I_EDGE_TOP;
                state_d = S_SH_E;
            end
            S_SH_E: begin
                if (accept) begin
                    for (int k = 0; k < N_EDGE; k++) begin
                        if (idx_t'(k) == i_q)    work_e_d[k] = e_at_r;
                        else if (idx_t'(k) == r) work_e_d[k] = e_at_i;
                    end
                    if (i_q == I_ONE) begin
                        i_d     = I_CENTER_TOP;
                        state_d = S_SH_C;
                    end else begin
                        i_d = i_q - I_ONE;
                    end
                end
            end
            S_SH_C: begin
                if (accept) begin
                    for (int k = 0; k < N_CENTER; k++) begin
                        if (idx_t'(k) == i_q)    work_c_d[k] = c_at_r;
                        else if (idx_t'(k) == r) work_c_d[k] = c_at_i;
                    end
                    if (i_q == I_ONE) begin
                        state_d  = S_DONE;
                        edge_d   = work_e_q;
                        center_d = work_c_d;
                    end else begin
                        i_d = i_q - I_ONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, LFSR, working arrays and output orders.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED_RST;
            i_q     <= '0;
            for (int k = 0; k < N_EDGE; k++) begin
                work_e_q[k] <= idx_t'(k);
                edge_q[k]   <= idx_t'(k);
            end
            for (int k = 0; k < N_CENTER; k++) begin
                work_c_q[k] <= idx_t'(k);
                center_q[k] <= idx_t'(k);
            end
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            i_q      <= i_d;
            work_e_q <= work_e_d;
            work_c_q <= work_c_d;
            edge_q   <= edge_d;
            center_q <= center_d;
        end
    end

    assign bus.busy = (state_q == S_INIT) ||
                      (state_q == S_SH_E) ||
                      (state_q == S_SH_C);
    assign bus.done = (state_q == S_DONE);

    for (genvar g = 0; g < N_EDGE; g++) begin : g_pack_e
        assign bus.edge_order[g*IDX_W +: IDX_W] = edge_q[g];
    end

    for (genvar g = 0; g < N_CENTER; g++) begin : g_pack_c
        assign bus.center_order[g*IDX_W +: IDX_W] = center_q[g];
    end
endmodule

// File: doc/tile_shuffler.md
# tile_shuffler

Parametrised board-tile order generator for the game core. On each `start` request it produces a fresh uniformly distributed permutation of the edge-track tiles and of the centre tiles using an LFSR-driven Fisher–Yates shuffle, then presents both packed orders on stable output registers. The board renderer and game FSM consume the orders. A seed-load port makes every shuffle reproducible for test and replay.

## Interface
- `N_EDGE`, 24, number of edge-track tiles (≥2)
- `N_CENTER`, 12, number of centre tiles (≥2)
- `IDX_W`, 5, bits per tile index; must satisfy 2^IDX_W ≥ max(N_EDGE, N_CENTER)
- `SEED_RST`, 16'hACE1, LFSR value at reset and substitute for an all-zero seed
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  shuffle request; sampled only in IDLE
- `seed_load`  in  1  load `seed` into LFSR this cycle
- `seed`  in  16  LFSR seed value
- `busy`  out  1  high while a shuffle is in progress
- `done`  out  1  one-cycle pulse; new orders are valid from this cycle onward
- `edge_order`  out  N_EDGE*IDX_W  slot k = bits [k*IDX_W +: IDX_W], value = tile id 0..N_EDGE-1
- `center_order`  out  N_CENTER*IDX_W  same packing, values 0..N_CENTER-1

## Operation
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400), shifts every cycle in every state. `seed_load` has priority over the shift. `seed`==0 loads SEED_RST.
- States: IDLE, INIT, SH_E, SH_C, DONE.
- IDLE: if `start`, go to INIT. `seed_load` and `start` in the same cycle are both honoured; the shuffle then uses the new seed's sequence.
- INIT (1 cycle): load the working arrays with identity (slot k = k). Set i = N_EDGE-1. Go to SH_E.
- SH_E, one step per cycle:
  - mask = smallest 2^m-1 ≥ i (OR-smear of i); r = lfsr & mask.
  - If r ≤ i: swap work_e[i] and work_e[r], then decrement i. Otherwise retry next cycle (rejection; acceptance ≥ 1/2).
  - When an accepted step has i==1, set i = N_CENTER-1 and go to SH_C.
- SH_C: same procedure on the centre array. After the accepted step with i==1, go to DONE.
- DONE (1 cycle): `done`=1. Copy the working arrays to `edge_order`/`center_order` on the edge entering DONE, so outputs change exactly when `done` rises. Return to IDLE.
- Outputs are registers and change only on entry to DONE or on reset. They hold the last result indefinitely.
- `start` outside IDLE is ignored; it is neither queued nor restarted.
- Swap with r==i is legal and leaves the array unchanged, but still counts as an accepted step.

## Timing
- Reset values:
  - `busy`=0, `done`=0, state IDLE, LFSR=SEED_RST.
  - `edge_order` and `center_order` hold identity (slot k = k).
- `busy`=1 in INIT, SH_E and SH_C; 0 in IDLE and DONE. `busy` rises the cycle after `start` is accepted.
- Latency, `start` to `done`: 2 + accepted steps + rejections. Accepted steps = (N_EDGE-1)+(N_CENTER-1) = 34 at defaults. Rejections are data-dependent with expected count ≤ accepted steps. Bench timeout: 1000 cycles.
- Earliest restart: back-to-back shuffles need `start` held or re-asserted in the IDLE cycle after DONE.
- Reset mid-shuffle: immediate return to IDLE. Outputs go to identity, `busy`/`done` to 0, and there is no `done` pulse.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle -> immediately `busy`=0, `done`=0, `edge_order` slot 5 = 5, `center_order` slot 11 = 11.
- Default shuffle: `start` 1 cycle after reset -> `busy` next cycle, exactly one `done` pulse within 1000 cycles. Each output is a permutation: all values 0..23 and 0..11 appear exactly once.
- Reproducibility: `seed_load`=1, `seed`=16'h1234 with `start`, twice -> both runs produce bit-identical orders and identical latency. `seed`=16'h0000 matches `seed`=16'hACE1.
- Ignore while busy: pulse `start` at cycles 3 and 10 of a shuffle -> single `done`, no restart, and `busy` stays continuous.
- Reset mid-shuffle: `rst` during SH_E -> identity outputs, no `done`. A following `start` completes normally.
- Small parameters: N_EDGE=4, N_CENTER=2, IDX_W=2 -> 10000 seeded runs give all 24 edge permutations and both centre orders, each within ±20% of the uniform count.
